// File: rtl/inert_spi_resp.sv
// Responder end of the 16-bit inertial SPI link (mode 3): config registers, sample bytes, INT.
// Optional build macro ODR_TIMER_EN replaces dat_vld with an internal sample-rate timer.
module inert_spi_resp #(
   parameter logic [7:0]  WHO_AM_I   = 8'h6A,
   parameter logic [15:0] ODR_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_rt_in,
   input  logic [15:0] az_in,
   input  logic        dat_vld,
   output logic        frm_done,
   output logic        frm_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_WAIT} state_t;

   state_t      r_state;
   logic        r_ss_s1, r_ss_s2, r_ss_h;
   logic        r_sck_s1, r_sck_s2, r_sck_h;
   logic        r_mosi_s1, r_mosi_s2;
   logic [4:0]  r_bit_cnt;
   logic [7:0]  r_cmd, r_dat, r_tx;
   logic        r_done, r_err, r_int;
   logic [7:0]  r_int1, r_ctrl1, r_ctrl2, r_ctrl4;
   logic [15:0] r_pt, r_az, r_pend_pt, r_pend_az;
   logic        r_pend, r_drdy;

   logic        w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
   logic        w_vld, w_xfer, w_rd_clr;
   logic [7:0]  w_rd_data;

   // Double-flop synchronizers plus history flops for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ss_s1   <= 1'b1;
         r_ss_s2   <= 1'b1;
         r_ss_h    <= 1'b1;
         r_sck_s1  <= 1'b1;
         r_sck_s2  <= 1'b1;
         r_sck_h   <= 1'b1;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_ss_s1   <= SS_n;
         r_ss_s2   <= r_ss_s1;
         r_ss_h    <= r_ss_s2;
         r_sck_s1  <= SCLK;
         r_sck_s2  <= r_sck_s1;
         r_sck_h   <= r_sck_s2;
         r_mosi_s1 <= MOSI;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   assign w_ss_fall  = r_ss_h & ~r_ss_s2;
   assign w_ss_rise  = ~r_ss_h & r_ss_s2;
   assign w_sck_rise = ~r_sck_h & r_sck_s2;
   assign w_sck_fall = r_sck_h & ~r_sck_s2;

   assign w_rd_clr = w_ss_rise & (r_bit_cnt == 5'd16) & r_cmd[7] & (r_cmd[6:0] == 7'h2D);
   assign w_xfer   = r_pend & r_ss_s2;

   // Register read mux addressed by the command byte
   always_comb begin
      w_rd_data = 8'h00;
      case (r_cmd[6:0])
         7'h0D:   w_rd_data = r_int1;
         7'h0F:   w_rd_data = WHO_AM_I;
         7'h10:   w_rd_data = r_ctrl1;
         7'h11:   w_rd_data = r_ctrl2;
         7'h14:   w_rd_data = r_ctrl4;
         7'h22:   w_rd_data = r_pt[7:0];
         7'h23:   w_rd_data = r_pt[15:8];
         7'h2C:   w_rd_data = r_az[7:0];
         7'h2D:   w_rd_data = r_az[15:8];
         default: w_rd_data = 8'h00;
      endcase
   end

   // Frame FSM: shift in cmd/data, drive MISO, commit writes when SS_n rises
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 5'd0;
         r_cmd     <= 8'h00;
         r_dat     <= 8'h00;
         r_tx      <= 8'h00;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_int1    <= 8'h00;
         r_ctrl1   <= 8'h00;
         r_ctrl2   <= 8'h00;
         r_ctrl4   <= 8'h00;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_tx    <= 8'h00;
            if (r_bit_cnt == 5'd16) begin
               r_done <= 1'b1;
               if (!r_cmd[7]) begin
                  case (r_cmd[6:0])
                     7'h0D:   r_int1  <= r_dat;
                     7'h10:   r_ctrl1 <= r_dat;
                     7'h11:   r_ctrl2 <= r_dat;
                     7'h14:   r_ctrl4 <= r_dat;
                     default: ;
                  endcase
               end
            end else begin
               r_err <= 1'b1;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_tx <= 8'h00;
                  if (w_ss_fall) begin
                     r_state   <= ST_CMD;
                     r_bit_cnt <= 5'd0;
                  end
               end
               ST_CMD: begin
                  if (w_sck_rise) begin
                     r_cmd     <= {r_cmd[6:0], r_mosi_s2};
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                     if (r_bit_cnt == 5'd7) r_state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (w_sck_rise) begin
                     r_dat     <= {r_dat[6:0], r_mosi_s2};
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                     if (r_bit_cnt == 5'd15) r_state <= ST_WAIT;
                  end
                  // First fall after the cmd byte loads read data for the same frame
                  if (w_sck_fall) begin
                     r_tx <= (r_bit_cnt == 5'd8) ? w_rd_data : {r_tx[6:0], 1'b0};
                  end
               end
               ST_WAIT: begin
                  if (w_sck_fall) r_tx <= {r_tx[6:0], 1'b0};
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef ODR_TIMER_EN
   logic [15:0] r_odr_cnt;

   assign w_vld = (r_ctrl1 != 8'h00) && (r_odr_cnt == ODR_CYCLES - 16'd1);

   // Sample-rate timer, held in reset while the accelerometer is powered down
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_odr_cnt <= 16'd0;
      end else if ((r_ctrl1 == 8'h00) || w_vld) begin
         r_odr_cnt <= 16'd0;
      end else begin
         r_odr_cnt <= r_odr_cnt + 16'd1;
      end
   end
`else
   // A zero sample period is meaningless; the term folds to a constant 1
   assign w_vld = dat_vld & (ODR_CYCLES != 16'd0);
`endif

   // Sample path: pending buffer, transfer only while deselected, drdy and INT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend    <= 1'b0;
         r_pend_pt <= 16'h0000;
         r_pend_az <= 16'h0000;
         r_pt      <= 16'h0000;
         r_az      <= 16'h0000;
         r_drdy    <= 1'b0;
         r_int     <= 1'b0;
      end else begin
         if (w_vld) begin
            r_pend_pt <= ptch_rt_in;
            r_pend_az <= az_in;
            r_pend    <= 1'b1;
         end else if (w_xfer) begin
            r_pend <= 1'b0;
         end
         if (w_xfer) begin
            r_pt   <= r_pend_pt;
            r_az   <= r_pend_az;
            r_drdy <= 1'b1;
         end else if (w_rd_clr) begin
            r_drdy <= 1'b0;
         end
         r_int <= r_drdy & r_int1[1];
      end
   end

   assign MISO     = r_tx[7];
   assign INT      = r_int;
   assign frm_done = r_done;
   assign frm_err  = r_err;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed bench for inert_spi_resp: SPI master model with a read-byte scoreboard.
module tb_inert_spi_resp;

   localparam int HALF = 10;

   logic        clk = 1'b0;
   logic        rst, SS_n, SCLK, MOSI, dat_vld;
   logic [15:0] ptch_rt_in, az_in;
   logic        MISO, INT, frm_done, frm_err;

   int n_pass = 0, n_tot = 0, n_fail = 0;
   int n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;
   logic [7:0] exp_q[$];

   inert_spi_resp dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .INT(INT), .ptch_rt_in(ptch_rt_in), .az_in(az_in), .dat_vld(dat_vld),
      .frm_done(frm_done), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frm_done === 1'b1) n_done++;
      if (frm_err === 1'b1) n_err++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_vld(input logic [15:0] pt, input logic [15:0] az);
      ptch_rt_in = pt;
      az_in      = az;
      dat_vld    = 1'b1;
      @(negedge clk);
      dat_vld    = 1'b0;
   endtask

   task automatic spi_frame(input logic [15:0] word, input int nbits, input int vld_bit,
                            input logic [15:0] vpt, input logic [15:0] vaz,
                            output logic [7:0] rx);
      logic [15:0] shin;
      shin = 16'h0000;
      SS_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = word[15-i];
         repeat (HALF) @(negedge clk);
         if (i == vld_bit) pulse_vld(vpt, vaz);
         shin = {shin[14:0], MISO};
         SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      if (vld_bit >= 0) chk("int_low_mid_frame", 16'(INT), 16'd0);
      SS_n = 1'b1;
      repeat (3 * HALF) @(negedge clk);
      if (nbits == 16) exp_done++;
      else exp_err++;
      rx = shin[7:0];
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      logic [7:0] rx;
      spi_frame({1'b0, a, d}, 16, -1, 16'h0000, 16'h0000, rx);
   endtask

   task automatic rd(input logic [6:0] a, input logic [7:0] e, input string tag);
      logic [7:0] rx, ex;
      exp_q.push_back(e);
      spi_frame({1'b1, a, 8'h00}, 16, -1, 16'h0000, 16'h0000, rx);
      ex = exp_q.pop_front();
      chk(tag, {8'h00, rx}, {8'h00, ex});
   endtask

   task automatic wait_int(input logic e, input int maxc, input string tag);
      int k;
      k = 0;
      while (INT !== e && k < maxc) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 16'(INT), 16'(e));
   endtask

   initial begin
      logic [7:0] rx;
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; dat_vld = 1'b0;
      ptch_rt_in = 16'h0000; az_in = 16'h0000;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // reset state and WHO_AM_I
      chk("rst_miso", 16'(MISO), 16'd0);
      chk("rst_int", 16'(INT), 16'd0);
      chk("rst_frm_done", 16'(frm_done), 16'd0);
      chk("rst_frm_err", 16'(frm_err), 16'd0);
      rd(7'h0F, 8'h6A, "who_am_i");
      rd(7'h0D, 8'h00, "int1_rst");
      rd(7'h10, 8'h00, "ctrl1_rst");

      // sample path and INT
      wr(7'h0D, 8'h02);
      rd(7'h0D, 8'h02, "int1_wr");
      pulse_vld(16'h1234, 16'hABCD);
      wait_int(1'b1, 3, "int_rise_3clk");
      rd(7'h22, 8'h34, "ptch_l");
      rd(7'h23, 8'h12, "ptch_h");
      rd(7'h2C, 8'hCD, "az_l");
      chk("int_held", 16'(INT), 16'd1);
      rd(7'h2D, 8'hAB, "az_h");
      chk("int_clr_az_h", 16'(INT), 16'd0);

      // truncated write frame
      spi_frame(16'h1053, 10, -1, 16'h0000, 16'h0000, rx);
      chk("trunc_err_cnt", 16'(n_err), 16'(exp_err));
      chk("trunc_done_cnt", 16'(n_done), 16'(exp_done));
      rd(7'h10, 8'h00, "ctrl1_no_wr");

      // sample arriving mid-frame waits for deselect
      exp_q.push_back(8'h34);
      spi_frame(16'hA200, 16, 4, 16'h5555, 16'h0F0F, rx);
      chk("mid_frame_old", {8'h00, rx}, {8'h00, exp_q.pop_front()});
      chk("int_after_ss", 16'(INT), 16'd1);
      rd(7'h22, 8'h55, "mid_frame_new_l");
      rd(7'h2D, 8'h0F, "mid_frame_new_az");
      chk("int_clr2", 16'(INT), 16'd0);

      // INT gated by INT1_CTRL, drdy retained
      wr(7'h0D, 8'h00);
      pulse_vld(16'h0102, 16'h0304);
      repeat (10) @(negedge clk);
      chk("int_masked", 16'(INT), 16'd0);
      wr(7'h0D, 8'h02);
      chk("int_unmasked", 16'(INT), 16'd1);

      // back-to-back samples, RO/unlisted writes, CTRL4
      pulse_vld(16'h1111, 16'h0000);
      pulse_vld(16'h2222, 16'h0000);
      repeat (5) @(negedge clk);
      rd(7'h22, 8'h22, "last_sample_wins");
      wr(7'h0F, 8'h55);
      rd(7'h0F, 8'h6A, "who_am_i_ro");
      wr(7'h22, 8'h99);
      rd(7'h22, 8'h22, "ptch_ro");
      wr(7'h14, 8'h77);
      rd(7'h14, 8'h77, "ctrl4_rw");
      wr(7'h11, 8'h3C);
      rd(7'h11, 8'h3C, "ctrl2_rw");
      rd(7'h50, 8'h00, "unlisted");
      chk("done_cnt", 16'(n_done), 16'(exp_done));
      chk("err_cnt", 16'(n_err), 16'(exp_err));

      // reset mid-frame aborts a write
      SS_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         SCLK = 1'b0;
         MOSI = (i == 3) || (i == 7);
         repeat (HALF) @(negedge clk);
         SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      SS_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3 * HALF) @(negedge clk);
      chk("rst_abort_int", 16'(INT), 16'd0);
      rd(7'h11, 8'h00, "rst_abort_ctrl2");
      rd(7'h0D, 8'h00, "rst_int1_cleared");
      rd(7'h22, 8'h00, "rst_ptch_cleared");
      chk("final_done_cnt", 16'(n_done), 16'(exp_done));
      chk("final_err_cnt", 16'(n_err), 16'(exp_err));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
